sweep_sched: RTL and testbench
==============================

# sweep_sched

Frequency-sweep scheduler for the learning path. It steps the DDS frequency index from a configured first bin to a last bin. At each point it waits a settle time, then requests one FFT-bin capture from the capture/write datapath and waits for that datapath's acknowledge, with a timeout. It sits between the key/UI logic and the DDS plus capture datapath, and supplies the point address used for the RAM writes.

## Interface
- `IDX_W`, 12: width of the frequency index and of the point address.
- `IDX_MAX`, 2751: highest legal bin index.
- `SETTLE_CYC`, 149_997: number of settle cycles after each frequency load (about 3 ms at 50 MHz).
- `TIMEOUT_CYC`, 500_000: maximum number of cycles `cap_req` may stay high without an acknowledge.
- `clk_50m`  in  1: the only clock.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `start`  in  1: level input; a sweep is started by its rising edge.
- `abort`  in  1: synchronous abort, active high.
- `idx_first`, `idx_last`, `idx_step`  in  IDX_W each: sweep configuration, sampled on the start edge.
- `cap_ack`  in  1: one-cycle capture-complete pulse from the capture datapath.
- `freq_idx`  out  IDX_W: current DDS frequency index.
- `freq_load`  out  1: one-cycle strobe telling the DDS that `freq_idx` is new.
- `cap_req`  out  1: capture request, held high until acknowledged.
- `wr_addr`  out  IDX_W: RAM address for the current point; valid while `cap_req` is high.
- `pt_cnt`  out  IDX_W: number of points completed in the current or last sweep.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse when a sweep completes normally.
- `err_cfg`, `err_timeout`  out  1 each: sticky error flags, cleared on the next accepted start.

## Operation
- Reset values: all outputs are 0, state is IDLE, and the internal `start_d` register resets to 1. Because of that, a `start` held high through reset release does not trigger a sweep.
- All outputs are registered.
- States (one-hot): IDLE, LOAD, SETTLE, CAPTURE, NEXT, DONE.
- IDLE: on a start rise (`start & ~start_d`), check the configuration.
  - Valid when `idx_step != 0`, `idx_first <= idx_last` and `idx_last <= IDX_MAX`.
  - Valid: latch first/last/step, set `cur = first`, clear `wr_addr`, `pt_cnt` and both error flags, then go to LOAD.
  - Invalid: set `err_cfg`, stay in IDLE, leave `busy` at 0.
- LOAD: `freq_idx <= cur`, `freq_load <= 1` for one cycle, clear the timer, go to SETTLE.
- SETTLE: count up to `SETTLE_CYC-1`, then set `cap_req <= 1`, clear the timer, go to CAPTURE.
- CAPTURE:
  - `cap_ack` high: `cap_req <= 0`, go to NEXT.
  - Otherwise, when the timer reaches `TIMEOUT_CYC-1`: set `err_timeout`, `cap_req <= 0`, go to IDLE. `done` is not pulsed.
- NEXT: `pt_cnt++`, then:
  - If `cur + step > last`, go to DONE. Compute the sum in IDX_W+1 bits so it cannot wrap.
  - Otherwise `cur += step`, `wr_addr++`, go to LOAD.
- DONE: `done <= 1` for one cycle, go to IDLE.
- Points per sweep = floor((last-first)/step)+1; the final index never exceeds `last`.
- `abort` in any non-IDLE state sends the block to IDLE at the next edge with `cap_req` = 0, `busy` = 0 and no `done`. `abort` takes priority over a simultaneous `cap_ack` or timeout, and `pt_cnt` keeps its value.
- A start rise while `busy` is ignored.
- `cap_ack` arriving outside CAPTURE is ignored.
- Reset mid-sweep returns the block to the reset values immediately.

## Timing
- Let E be the edge at which the start rise is detected.
  - After E: `busy` = 1, state = LOAD.
  - After E+1: `freq_idx` is valid and `freq_load` = 1 for one cycle.
  - After E+1+`SETTLE_CYC`: `cap_req` = 1.
- Let A be the edge at which `cap_ack` is sampled high.
  - After A: `cap_req` = 0.
  - After A+1: `pt_cnt` is incremented.
  - After A+2: either the next `freq_load` is high, or (for the last point) `done` is high.
  - After A+3 (last point only): `busy` = 0.
- Timeout: `err_timeout` rises exactly `TIMEOUT_CYC` cycles after `cap_req` rises.
- The shared timer is 20 bits wide and saturates rather than wrapping.

## Structure
- Shared package `learn_pkg` holds:
  - the one-hot state encoding constants;
  - `IDX_W` and `IDX_MAX`;
  - the default `SETTLE_CYC` and `TIMEOUT_CYC`.
- One sub-module, `sweep_timer`: a clearable, saturating 20-bit counter with a terminal-count compare. It is shared by SETTLE and CAPTURE; the terminal value is selected by state.

## Test plan
- first=10, last=30, step=10, SETTLE_CYC=8, ack 3 cycles after each `cap_req` -> `freq_idx` 10/20/30 with three `freq_load` pulses, `wr_addr` 0/1/2, one `done`, `pt_cnt`=3.
- first=0, last=2751, step=1000 -> points 0, 1000, 2000 only; no wrap; `done` once; `pt_cnt`=3.
- TIMEOUT_CYC=16, `cap_ack` never asserted -> `err_timeout`=1 exactly 16 cycles after `cap_req` rises, `cap_req`=0, `busy`=0, no `done`.
- `abort` during SETTLE, and separately `abort` in the same cycle as `cap_ack` -> IDLE next edge, no `done`, `pt_cnt` unchanged.
- Invalid configurations (step=0; first=40 with last=30; last=2752) -> `err_cfg`=1, `busy` stays 0, no `freq_load`. A following valid start clears `err_cfg`.
- `rst_n` asserted in CAPTURE with `start` held high through release -> all outputs 0 and no new sweep until `start` falls and rises again.

Source files
------------

// File: rtl/learn_pkg.sv
// Shared constants and types for the learning-path sweep logic:
// index width/range, default timing, and the sweep FSM state encoding.
package learn_pkg;

  localparam int IDX_W           = 12;
  localparam int IDX_MAX         = 2751;
  localparam int SETTLE_CYC_DEF  = 149_997;
  localparam int TIMEOUT_CYC_DEF = 500_000;
  localparam int TMR_W           = 20;

  // One-hot encoding keeps each state decode to a single bit.
  typedef enum logic [5:0] {
    ST_IDLE    = 6'b000001,
    ST_LOAD    = 6'b000010,
    ST_SETTLE  = 6'b000100,
    ST_CAPTURE = 6'b001000,
    ST_NEXT    = 6'b010000,
    ST_DONE    = 6'b100000
  } sweep_state_e;

  // A sweep must step forward, be non-empty and stay inside the bin table.
  function automatic logic cfg_valid(input logic [IDX_W-1:0] first,
                                     input logic [IDX_W-1:0] last,
                                     input logic [IDX_W-1:0] step);
    return (step != '0) && (first <= last) && (last <= IDX_W'(IDX_MAX));
  endfunction

endpackage

// File: rtl/sweep_timer.sv
// Clearable, saturating up-counter with a terminal-count compare.
// The caller chooses the terminal value, so one counter serves both the
// settle wait and the capture timeout.
module sweep_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, otherwise count up and stick at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == term);

endmodule

// File: rtl/sweep_sched.sv
// Frequency-sweep scheduler: walks the DDS index from first to last bin,
// waits a settle time at each point, then requests one capture and waits
// for its acknowledge (with timeout). Also supplies the RAM point address.
module sweep_sched
  import learn_pkg::*;
#(
  parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk_50m,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [IDX_W-1:0] idx_first,
  input  logic [IDX_W-1:0] idx_last,
  input  logic [IDX_W-1:0] idx_step,
  input  logic             cap_ack,
  output logic [IDX_W-1:0] freq_idx,
  output logic             freq_load,
  output logic             cap_req,
  output logic [IDX_W-1:0] wr_addr,
  output logic [IDX_W-1:0] pt_cnt,
  output logic             busy,
  output logic             done,
  output logic             err_cfg,
  output logic             err_timeout
);

  localparam logic [TMR_W-1:0] SETTLE_TERM  = TMR_W'(SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_TERM = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_ONE      = IDX_W'(1);

  sweep_state_e state_q, state_d;

  logic             start_d_q, start_d_d;
  logic [IDX_W-1:0] cur_q, cur_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] step_q, step_d;
  logic [IDX_W-1:0] freq_idx_q, freq_idx_d;
  logic             freq_load_q, freq_load_d;
  logic             cap_req_q, cap_req_d;
  logic [IDX_W-1:0] wr_addr_q, wr_addr_d;
  logic [IDX_W-1:0] pt_cnt_q, pt_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_cfg_q, err_cfg_d;
  logic             err_timeout_q, err_timeout_d;

  logic             start_rise;
  logic [IDX_W:0]   next_sum;
  logic             tmr_clr;
  logic             tmr_en;
  logic [TMR_W-1:0] tmr_term;
  logic             tmr_tc;

  assign start_rise = start & ~start_d_q;

  // One extra bit so cur + step can never wrap past last.
  assign next_sum = {1'b0, cur_q} + {1'b0, step_q};

  // The shared timer compares against the settle or timeout limit by state.
  assign tmr_term = (state_q == ST_SETTLE) ? SETTLE_TERM : TIMEOUT_TERM;

  sweep_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk   (clk_50m),
    .rst_n (rst_n),
    .clr   (tmr_clr),
    .en    (tmr_en),
    .term  (tmr_term),
    .tc    (tmr_tc)
  );

  // Next-state and registered-output logic for the sweep FSM.
  always_comb begin
    state_d       = state_q;
    start_d_d     = start;
    cur_d         = cur_q;
    last_d        = last_q;
    step_d        = step_q;
    freq_idx_d    = freq_idx_q;
    freq_load_d   = 1'b0;
    cap_req_d     = cap_req_q;
    wr_addr_d     = wr_addr_q;
    pt_cnt_d      = pt_cnt_q;
    done_d        = 1'b0;
    err_cfg_d     = err_cfg_q;
    err_timeout_d = err_timeout_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          if (cfg_valid(idx_first, idx_last, idx_step)) begin
            last_d        = idx_last;
            step_d        = idx_step;
            cur_d         = idx_first;
            wr_addr_d     = '0;
            pt_cnt_d      = '0;
            err_cfg_d     = 1'b0;
            err_timeout_d = 1'b0;
            state_d       = ST_LOAD;
          end else begin
            err_cfg_d = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        freq_idx_d  = cur_q;
        freq_load_d = 1'b1;
        tmr_clr     = 1'b1;
        state_d     = ST_SETTLE;
      end
      ST_SETTLE: begin
        tmr_en = 1'b1;
        if (tmr_tc) begin
          cap_req_d = 1'b1;
          tmr_clr   = 1'b1;
          state_d   = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        tmr_en = 1'b1;
        if (cap_ack) begin
          cap_req_d = 1'b0;
          state_d   = ST_NEXT;
        end else if (tmr_tc) begin
          err_timeout_d = 1'b1;
          cap_req_d     = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      ST_NEXT: begin
        pt_cnt_d = pt_cnt_q + IDX_ONE;
        if (next_sum > {1'b0, last_q}) begin
          state_d = ST_DONE;
        end else begin
          cur_d     = next_sum[IDX_W-1:0];
          wr_addr_d = wr_addr_q + IDX_ONE;
          state_d   = ST_LOAD;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        cap_req_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    // Abort overrides whatever the state wanted, including an ack or timeout
    // in the same cycle; completed-point bookkeeping is left untouched.
    if (abort && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      cap_req_d     = 1'b0;
      freq_load_d   = 1'b0;
      done_d        = 1'b0;
      cur_d         = cur_q;
      wr_addr_d     = wr_addr_q;
      pt_cnt_d      = pt_cnt_q;
      err_timeout_d = err_timeout_q;
      freq_idx_d    = freq_idx_q;
      tmr_clr       = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers; start_d resets high so a start held through
  // reset release is not mistaken for a rising edge.
  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      start_d_q     <= 1'b1;
      cur_q         <= '0;
      last_q        <= '0;
      step_q        <= '0;
      freq_idx_q    <= '0;
      freq_load_q   <= 1'b0;
      cap_req_q     <= 1'b0;
      wr_addr_q     <= '0;
      pt_cnt_q      <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_cfg_q     <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      start_d_q     <= start_d_d;
      cur_q         <= cur_d;
      last_q        <= last_d;
      step_q        <= step_d;
      freq_idx_q    <= freq_idx_d;
      freq_load_q   <= freq_load_d;
      cap_req_q     <= cap_req_d;
      wr_addr_q     <= wr_addr_d;
      pt_cnt_q      <= pt_cnt_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_cfg_q     <= err_cfg_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  assign freq_idx    = freq_idx_q;
  assign freq_load   = freq_load_q;
  assign cap_req     = cap_req_q;
  assign wr_addr     = wr_addr_q;
  assign pt_cnt      = pt_cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_cfg     = err_cfg_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_sweep_sched.sv
// Directed bench for sweep_sched with short settle/timeout values.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sweep_sched;

  localparam int SETTLE  = 8;
  localparam int TIMEOUT = 16;

  logic        clk_50m = 1'b0;
  logic        rst_n   = 1'b0;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic [11:0] idx_first = '0;
  logic [11:0] idx_last  = '0;
  logic [11:0] idx_step  = '0;
  logic        cap_ack = 1'b0;
  logic [11:0] freq_idx;
  logic        freq_load;
  logic        cap_req;
  logic [11:0] wr_addr;
  logic [11:0] pt_cnt;
  logic        busy;
  logic        done;
  logic        err_cfg;
  logic        err_timeout;

  int checks    = 0;
  int errors    = 0;
  int doneCnt   = 0;
  int loadCnt   = 0;
  int doneSnap  = 0;
  int loadSnap  = 0;

  sweep_sched #(
    .SETTLE_CYC  (SETTLE),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk_50m     (clk_50m),
    .rst_n       (rst_n),
    .start       (start),
    .abort       (abort),
    .idx_first   (idx_first),
    .idx_last    (idx_last),
    .idx_step    (idx_step),
    .cap_ack     (cap_ack),
    .freq_idx    (freq_idx),
    .freq_load   (freq_load),
    .cap_req     (cap_req),
    .wr_addr     (wr_addr),
    .pt_cnt      (pt_cnt),
    .busy        (busy),
    .done        (done),
    .err_cfg     (err_cfg),
    .err_timeout (err_timeout)
  );

  // 50 MHz clock.
  always #10 clk_50m = ~clk_50m;

  // Safety net so a stuck run still ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge and tally output pulses seen there.
  task automatic tick();
    @(negedge clk_50m);
    if (done) doneCnt++;
    if (freq_load) loadCnt++;
  endtask

  // Raise start with a configuration; returns at the negedge after E+1.
  task automatic applyStimulus(input logic [11:0] first, input logic [11:0] last,
                               input logic [11:0] stp, input bit valid, input bit hold);
    idx_first = first;
    idx_last  = last;
    idx_step  = stp;
    start     = 1'b1;
    tick();
    if (valid) begin
      checkOutput("start_busy", busy, 1);
      checkOutput("start_err_cfg", err_cfg, 0);
      checkOutput("start_err_timeout", err_timeout, 0);
    end else begin
      checkOutput("bad_err_cfg", err_cfg, 1);
      checkOutput("bad_busy", busy, 0);
    end
    if (!hold) start = 1'b0;
    tick();
  endtask

  // One sweep point, entered at the negedge right after its LOAD edge.
  task automatic doPoint(input logic [11:0] expIdx, input logic [11:0] expAddr,
                         input bit isLast, input int ackDelay);
    checkOutput("freq_load", freq_load, 1);
    checkOutput("freq_idx", freq_idx, expIdx);
    repeat (SETTLE - 1) tick();
    checkOutput("cap_req_early", cap_req, 0);
    tick();
    checkOutput("cap_req_rise", cap_req, 1);
    checkOutput("wr_addr", wr_addr, expAddr);
    repeat (ackDelay - 1) tick();
    cap_ack = 1'b1;
    tick();
    cap_ack = 1'b0;
    checkOutput("cap_req_clear", cap_req, 0);
    tick();
    checkOutput("pt_cnt", pt_cnt, 32'(expAddr) + 1);
    tick();
    if (isLast) begin
      checkOutput("done_pulse", done, 1);
      checkOutput("no_extra_load", freq_load, 0);
      tick();
      checkOutput("done_busy", busy, 0);
      checkOutput("done_width", done, 0);
    end else begin
      checkOutput("no_early_done", done, 0);
    end
  endtask

  initial begin
    // Reset state
    tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_cap_req", cap_req, 0);
    checkOutput("rst_freq_idx", freq_idx, 0);
    checkOutput("rst_pt_cnt", pt_cnt, 0);
    rst_n = 1'b1;
    tick();
    tick();

    // Basic three-point sweep 10/20/30
    doneSnap = doneCnt; loadSnap = loadCnt;
    applyStimulus(12'd10, 12'd30, 12'd10, 1'b1, 1'b0);
    doPoint(12'd10, 12'd0, 1'b0, 3);
    doPoint(12'd20, 12'd1, 1'b0, 3);
    doPoint(12'd30, 12'd2, 1'b1, 3);
    checkOutput("t1_pt_cnt", pt_cnt, 3);
    checkOutput("t1_loads", loadCnt - loadSnap, 3);
    checkOutput("t1_dones", doneCnt - doneSnap, 1);

    // Wide sweep to the top of the table: 0, 1000, 2000 only
    doneSnap = doneCnt; loadSnap = loadCnt;
    applyStimulus(12'd0, 12'd2751, 12'd1000, 1'b1, 1'b0);
    doPoint(12'd0, 12'd0, 1'b0, 1);
    doPoint(12'd1000, 12'd1, 1'b0, 2);
    doPoint(12'd2000, 12'd2, 1'b1, 4);
    checkOutput("t2_pt_cnt", pt_cnt, 3);
    checkOutput("t2_loads", loadCnt - loadSnap, 3);
    checkOutput("t2_dones", doneCnt - doneSnap, 1);

    // Capture timeout with no acknowledge
    doneSnap = doneCnt;
    applyStimulus(12'd5, 12'd5, 12'd1, 1'b1, 1'b0);
    checkOutput("t3_freq_load", freq_load, 1);
    repeat (SETTLE) tick();
    checkOutput("t3_cap_req", cap_req, 1);
    repeat (TIMEOUT - 1) tick();
    checkOutput("t3_err_early", err_timeout, 0);
    checkOutput("t3_req_held", cap_req, 1);
    tick();
    checkOutput("t3_err_timeout", err_timeout, 1);
    checkOutput("t3_cap_req_off", cap_req, 0);
    checkOutput("t3_busy", busy, 0);
    tick();
    checkOutput("t3_no_done", doneCnt - doneSnap, 0);

    // Abort during SETTLE of the second point
    doneSnap = doneCnt;
    applyStimulus(12'd1, 12'd2, 12'd1, 1'b1, 1'b0);
    doPoint(12'd1, 12'd0, 1'b0, 2);
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t4a_busy", busy, 0);
    checkOutput("t4a_cap_req", cap_req, 0);
    repeat (SETTLE + 2) tick();
    checkOutput("t4a_pt_cnt", pt_cnt, 1);
    checkOutput("t4a_cap_req_late", cap_req, 0);
    checkOutput("t4a_no_done", doneCnt - doneSnap, 0);

    // Abort in the same cycle as the acknowledge
    doneSnap = doneCnt;
    applyStimulus(12'd0, 12'd1, 12'd1, 1'b1, 1'b0);
    doPoint(12'd0, 12'd0, 1'b0, 2);
    checkOutput("t4b_freq_idx", freq_idx, 1);
    repeat (SETTLE) tick();
    checkOutput("t4b_cap_req", cap_req, 1);
    cap_ack = 1'b1;
    abort   = 1'b1;
    tick();
    cap_ack = 1'b0;
    abort   = 1'b0;
    checkOutput("t4b_cap_req_off", cap_req, 0);
    checkOutput("t4b_busy", busy, 0);
    tick();
    tick();
    checkOutput("t4b_pt_cnt", pt_cnt, 1);
    checkOutput("t4b_no_done", doneCnt - doneSnap, 0);

    // Invalid configurations, then a valid start clears err_cfg
    loadSnap = loadCnt;
    applyStimulus(12'd5, 12'd30, 12'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(12'd40, 12'd30, 12'd1, 1'b0, 1'b0);
    tick();
    applyStimulus(12'd0, 12'd2752, 12'd1, 1'b0, 1'b0);
    tick();
    checkOutput("t5_busy", busy, 0);
    checkOutput("t5_no_load", loadCnt - loadSnap, 0);
    applyStimulus(12'd7, 12'd7, 12'd3, 1'b1, 1'b0);
    doPoint(12'd7, 12'd0, 1'b1, 2);
    checkOutput("t5_pt_cnt", pt_cnt, 1);

    // Reset in CAPTURE with start held high through release
    applyStimulus(12'd3, 12'd3, 12'd1, 1'b1, 1'b1);
    repeat (SETTLE) tick();
    checkOutput("t6_cap_req", cap_req, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_cap_req", cap_req, 0);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_freq_idx", freq_idx, 0);
    checkOutput("t6_rst_pt_cnt", pt_cnt, 0);
    checkOutput("t6_rst_err", {30'd0, err_cfg, err_timeout}, 0);
    tick();
    loadSnap = loadCnt;
    rst_n = 1'b1;
    repeat (4) tick();
    checkOutput("t6_no_sweep", busy, 0);
    checkOutput("t6_no_load", loadCnt - loadSnap, 0);
    start = 1'b0;
    tick();
    start = 1'b1;
    tick();
    checkOutput("t6_restart_busy", busy, 1);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checkOutput("t6_abort_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
